// File: rtl/microseq_cpu_pkg.sv
// Shared definitions for the microsequenced accumulator CPU: opcodes,
// FSM states and the bit positions of the flags in o_flags.
package microseq_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        EXEC0  = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Opcodes 9..13 are unassigned; they run as NOP but get reported.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd13);
    endfunction

    // Instructions that go through EXEC1 to touch memory at the operand address.
    function automatic logic uses_mem(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/microseq_alu.sv
// Combinational add/subtract unit. Subtraction is A + ~B + 1, so the carry
// out is 1 exactly when no borrow occurred (A >= B unsigned).
module microseq_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    // One adder serves both operations; the carry-in doubles as the +1 of two's complement.
    always_comb begin
        b_eff  = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        zero   = (sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/microseq_cpu.sv
// Tiny accumulator CPU with a multi-cycle fetch/execute sequencer, a shared
// program/data memory and an external write port for loading programs.
module microseq_cpu
    import microseq_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    output logic [DATA_W-1:0] o_out,
    output logic              o_out_valid,
    output logic              o_halted,
    output logic              o_illegal,
    output logic [ADDR_W-1:0] o_pc,
    output logic [1:0]        o_flags
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c;
    logic              z;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid;
    logic              halted;
    logic              illegal;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              prog_accept;
    logic              sta_write;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];
    assign mem_rd  = mem[mar];

    // The loader only gets the memory while the core is parked, so it can never race an STA.
    assign prog_accept = ((state == FETCH0) && !i_run) || (state == HALT);
    assign sta_write   = (state == EXEC1) && (opcode == OP_STA);

    microseq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a),
        .b      (b),
        .sub    (opcode == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= FETCH0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: memory instructions take EXEC1, ALU ops also take EXEC2.
    always_comb begin
        next_state = state;
        case (state)
            FETCH0: begin
                if (i_run) begin
                    next_state = FETCH1;
                end
            end
            FETCH1: next_state = EXEC0;
            EXEC0: begin
                if (uses_mem(opcode)) begin
                    next_state = EXEC1;
                end else if (opcode == OP_HLT) begin
                    next_state = HALT;
                end else begin
                    next_state = FETCH0;
                end
            end
            EXEC1: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    next_state = EXEC2;
                end else begin
                    next_state = FETCH0;
                end
            end
            EXEC2:   next_state = FETCH0;
            HALT:    next_state = HALT;
            default: next_state = FETCH0;
        endcase
    end

    // Datapath registers, updated according to the current sequencer step.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= 1'b0;
            z         <= 1'b0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH0: begin
                    if (i_run) begin
                        mar <= pc;
                    end
                end
                FETCH1: begin
                    ir <= mem_rd;
                    pc <= pc + 1'b1;
                end
                EXEC0: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                        OP_LDI: a  <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                        OP_JMP: pc <= operand;
                        OP_JC: begin
                            if (c) begin
                                pc <= operand;
                            end
                        end
                        OP_JZ: begin
                            if (z) begin
                                pc <= operand;
                            end
                        end
                        OP_OUT: begin
                            out_reg   <= a;
                            out_valid <= 1'b1;
                        end
                        OP_HLT: halted <= 1'b1;
                        default: begin
                            if (is_illegal(opcode)) begin
                                illegal <= 1'b1;
                            end
                        end
                    endcase
                end
                EXEC1: begin
                    if (opcode == OP_LDA) begin
                        a <= mem_rd;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        b <= mem_rd;
                    end
                end
                EXEC2: begin
                    a <= alu_result;
                    c <= alu_carry;
                    z <= alu_zero;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory is deliberately not reset so a loaded program survives a reset.
    always_ff @(posedge i_clk) begin
        if (sta_write) begin
            mem[mar] <= a;
        end else if (i_prog_we && prog_accept) begin
            mem[i_prog_addr] <= i_prog_data;
        end
    end

    assign o_out          = out_reg;
    assign o_out_valid    = out_valid;
    assign o_halted       = halted;
    assign o_illegal      = illegal;
    assign o_pc           = pc;
    assign o_flags[FLAG_C] = c;
    assign o_flags[FLAG_Z] = z;

endmodule
